dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder with a fixed wait-state count per request.
// Misaligned, out-of-range and read+write requests complete with the same timing and are flagged.
module dmem_responder #(
    parameter int N     = 64,
    parameter int DEPTH = 32,
    parameter int WAIT  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] DM_readData,
    output logic         DM_ready,
    output logic         DM_error
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [N-1:0]   addr_q, addr_d;
    logic [N-1:0]   wdata_q, wdata_d;
    logic           we_q, we_d;
    logic           re_q, re_d;
    logic [N-1:0]   rdata_q, rdata_d;
    logic           ready_q, ready_d;
    logic           error_q, error_d;

    logic [N-1:0]   mem_q [DEPTH];

    logic [N-1:0]   eff_addr_s;
    logic [N-1:0]   eff_wdata_s;
    logic           eff_we_s;
    logic           eff_re_s;
    logic [AW-1:0]  eff_idx_s;
    logic [N-1:0]   addr_hi_s;
    logic           err_s;
    logic           wr_ok_s;
    logic           rd_ok_s;
    logic           go_resp_s;
    logic           latch_s;
    logic           mem_we_s;

    // Request currently being decided: live inputs in IDLE (zero-wait case), latched copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            eff_addr_s  = DM_addr;
            eff_wdata_s = DM_writeData;
            eff_we_s    = DM_writeEnable;
            eff_re_s    = DM_readEnable;
        end else begin
            eff_addr_s  = addr_q;
            eff_wdata_s = wdata_q;
            eff_we_s    = we_q;
            eff_re_s    = re_q;
        end
    end

    assign eff_idx_s = eff_addr_s[AW+2:3];
    assign addr_hi_s = eff_addr_s >> (AW + 3);
    assign err_s     = (eff_we_s & eff_re_s) | (|eff_addr_s[2:0]) | (|addr_hi_s);
    assign wr_ok_s   = eff_we_s & ~err_s;
    assign rd_ok_s   = eff_re_s & ~err_s;
    // Reset gating keeps a request visible while reset is low from ever reaching the array.
    assign mem_we_s  = go_resp_s & wr_ok_s & reset;

    // Next-state, wait counter and response decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_s   = 1'b0;
        go_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (DM_readEnable || DM_writeEnable) begin
                    latch_s = 1'b1;
                    if (WAIT == 0) begin
                        state_d   = ST_RESP;
                        cnt_d     = 4'd0;
                        go_resp_s = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = WAIT_C;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d   = ST_RESP;
                    go_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request capture and registered response values.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        re_d    = re_q;
        if (latch_s) begin
            addr_d  = DM_addr;
            wdata_d = DM_writeData;
            we_d    = DM_writeEnable;
            re_d    = DM_readEnable;
        end else begin
            addr_d  = addr_q;
        end
        ready_d = go_resp_s;
        error_d = go_resp_s & err_s;
        rdata_d = rdata_q;
        if (go_resp_s && err_s) begin
            rdata_d = {N{1'b0}};
        end else if (go_resp_s && rd_ok_s) begin
            rdata_d = mem_q[eff_idx_s];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= {N{1'b0}};
            wdata_q <= {N{1'b0}};
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rdata_q <= {N{1'b0}};
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // Storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[eff_idx_s] <= eff_wdata_s;
        end
    end

    assign DM_readData = rdata_q;
    assign DM_ready    = ready_q;
    assign DM_error    = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a WAIT=2 instance for the main scenarios and a WAIT=0 instance for back-to-back reads.
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    logic [63:0] addr, wdata, rdata;
    logic        we, re, ready, error;

    logic [63:0] addr0, wdata0, rdata0;
    logic        we0, re0, ready0, error0;

    int total;
    int bad;

    dmem_responder #(.N(64), .DEPTH(32), .WAIT(2)) u_dut (
        .clk(clk), .reset(reset), .DM_addr(addr), .DM_writeData(wdata),
        .DM_writeEnable(we), .DM_readEnable(re),
        .DM_readData(rdata), .DM_ready(ready), .DM_error(error)
    );

    dmem_responder #(.N(64), .DEPTH(32), .WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .DM_addr(addr0), .DM_writeData(wdata0),
        .DM_writeEnable(we0), .DM_readEnable(re0),
        .DM_readData(rdata0), .DM_ready(ready0), .DM_error(error0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the WAIT=2 instance; called and returning just after a falling edge.
    task automatic txn(input string tag, input logic w, input logic r,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic exp_err, input logic [63:0] exp_rd);
        int cyc;
        we = w; re = r; addr = a; wdata = d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ready !== 1'b1 && cyc < 20);
        check({tag, ".latency"}, 64'(cyc), 64'd4);
        check({tag, ".error"}, {63'd0, error}, {63'd0, exp_err});
        check({tag, ".rdata"}, rdata, exp_rd);
        we = 1'b0; re = 1'b0;
        @(negedge clk);
        check({tag, ".pulse"}, {62'd0, ready, error}, 64'd0);
    endtask

    // One request on the WAIT=0 instance.
    task automatic txn0(input string tag, input logic w, input logic r,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic exp_err, input logic [63:0] exp_rd);
        int cyc;
        we0 = w; re0 = r; addr0 = a; wdata0 = d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ready0 !== 1'b1 && cyc < 20);
        check({tag, ".latency"}, 64'(cyc), 64'd1);
        check({tag, ".error"}, {63'd0, error0}, {63'd0, exp_err});
        check({tag, ".rdata"}, rdata0, exp_rd);
        we0 = 1'b0; re0 = 1'b0;
        @(negedge clk);
        check({tag, ".pulse"}, {62'd0, ready0, error0}, 64'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        we = 1'b0; re = 1'b0; addr = 64'd0; wdata = 64'd0;
        we0 = 1'b0; re0 = 1'b0; addr0 = 64'd0; wdata0 = 64'd0;

        repeat (3) @(negedge clk);
        check("reset.outs", {rdata[0], ready, error, 61'd0} | {1'b0, rdata[63:1]}, 64'd0);
        check("reset.outs0", {rdata0[0], ready0, error0, 61'd0} | {1'b0, rdata0[63:1]}, 64'd0);
        reset = 1'b1;

        txn("wr10", 1'b1, 1'b0, 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'd0);
        txn("rd10", 1'b0, 1'b1, 64'h10, 64'd0, 1'b0, 64'hDEADBEEF_CAFEF00D);
        txn("wr00", 1'b1, 1'b0, 64'h00, 64'h1111_1111_1111_1111, 1'b0, 64'hDEADBEEF_CAFEF00D);
        txn("wr08", 1'b1, 1'b0, 64'h08, 64'h2222_2222_2222_2222, 1'b0, 64'hDEADBEEF_CAFEF00D);
        txn("wr18", 1'b1, 1'b0, 64'h18, 64'h3333_3333_3333_3333, 1'b0, 64'hDEADBEEF_CAFEF00D);
        txn("wrF8", 1'b1, 1'b0, 64'hF8, 64'h7777_0000_7777_0000, 1'b0, 64'hDEADBEEF_CAFEF00D);
        txn("rdF8", 1'b0, 1'b1, 64'hF8, 64'd0, 1'b0, 64'h7777_0000_7777_0000);

        txn("rd0C_mis", 1'b0, 1'b1, 64'h0C, 64'd0, 1'b1, 64'd0);
        txn("rd10_again", 1'b0, 1'b1, 64'h10, 64'd0, 1'b0, 64'hDEADBEEF_CAFEF00D);
        txn("wr100_oor", 1'b1, 1'b0, 64'h100, 64'h9999_9999_9999_9999, 1'b1, 64'd0);
        txn("rd00", 1'b0, 1'b1, 64'h00, 64'd0, 1'b0, 64'h1111_1111_1111_1111);
        txn("both08", 1'b1, 1'b1, 64'h08, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 64'd0);
        txn("rd08", 1'b0, 1'b1, 64'h08, 64'd0, 1'b0, 64'h2222_2222_2222_2222);
        txn("wr10_keep", 1'b1, 1'b0, 64'h10, 64'h4444_4444_4444_4444, 1'b0, 64'h2222_2222_2222_2222);

        // Abort a write to 0x18 while it is waiting.
        we = 1'b1; addr = 64'h18; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort.rdata", rdata, 64'd0);
        check("abort.flags", {62'd0, ready, error}, 64'd0);
        we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        txn("rd18_after_abort", 1'b0, 1'b1, 64'h18, 64'd0, 1'b0, 64'h3333_3333_3333_3333);
        txn("rd10_new", 1'b0, 1'b1, 64'h10, 64'd0, 1'b0, 64'h4444_4444_4444_4444);

        // Zero-wait instance: fill two words, then hold read enable across consecutive requests.
        txn0("z.wr00", 1'b1, 1'b0, 64'h00, 64'hA5A5_0000_A5A5_0001, 1'b0, 64'd0);
        txn0("z.wr08", 1'b1, 1'b0, 64'h08, 64'h5A5A_0000_5A5A_0002, 1'b0, 64'd0);
        re0 = 1'b1; addr0 = 64'h00;
        @(negedge clk);
        check("z.b2b.r1.ready", {63'd0, ready0}, 64'd1);
        check("z.b2b.r1.data", rdata0, 64'hA5A5_0000_A5A5_0001);
        addr0 = 64'h08;
        @(negedge clk);
        check("z.b2b.gap1", {62'd0, ready0, error0}, 64'd0);
        @(negedge clk);
        check("z.b2b.r2.ready", {63'd0, ready0}, 64'd1);
        check("z.b2b.r2.data", rdata0, 64'h5A5A_0000_5A5A_0002);
        addr0 = 64'h00;
        @(negedge clk);
        check("z.b2b.gap2", {62'd0, ready0, error0}, 64'd0);
        @(negedge clk);
        check("z.b2b.r3.ready", {63'd0, ready0}, 64'd1);
        check("z.b2b.r3.data", rdata0, 64'hA5A5_0000_A5A5_0001);
        re0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("z.idle", {62'd0, ready0, error0}, 64'd0);
        txn0("z.mis", 1'b0, 1'b1, 64'h04, 64'd0, 1'b1, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
